gpc_sum_accum: RTL and testbench
================================

Name: gpc_sum_accum

Overview:
- Streaming accumulator directly downstream of gpc606_5.
- Consumes one 5-bit GPC result per beat (range 0..30: six weight-1 bits plus six weight-4 bits) and sums the beats of a frame.
- Emits one frame total with a beat count and error flags.
- Valid/ready on both sides; one output register stage; no combinational path from out_ready to in_ready except through state.

Parameters:
- IN_W, 5, width of the GPC result input.
- MAX_IN, 30, largest legal input value (6*1 + 6*4).
- ACC_W, 16, accumulator/result width; saturates at 2^ACC_W-1.
- CNT_W, 8, beat-counter width; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts beat this cycle.
- in_data  in  IN_W  GPC result (dst of gpc606_5).
- in_last  in  1  beat is last of frame.
- out_valid  out  1  frame total available.
- out_ready  in  1  consumer accepts total.
- out_sum  out  ACC_W  frame total.
- out_beats  out  CNT_W  beats in frame.
- out_ovf  out  1  accumulator saturated during frame.
- out_err  out  1  some beat had in_data > MAX_IN.

Behaviour:
- Reset (async assert, sync release): state=ACCUM, acc=0, cnt=0, ovf/err sticky=0; out_valid=0, out_sum=0, out_beats=0, out_ovf=0, out_err=0; in_ready=1 from first cycle after release.
- Two states: ACCUM and HOLD.
- ACCUM:
  - in_ready=1.
  - Accepted beat (in_valid&in_ready) with in_last=0: acc <= sat(acc+in_data); cnt <= sat(cnt+1); ovf |= acc+in_data exceeds max; err |= in_data>MAX_IN.
  - Accepted beat with in_last=1: out_sum/out_beats/out_ovf/out_err load final values including this beat; out_valid<=1; acc, cnt and flags clear; goto HOLD.
  - Latency: the total is visible on the cycle after the last beat is accepted.
- HOLD:
  - in_ready=0; outputs stable while out_valid=1 and out_ready=0.
  - out_valid&out_ready: out_valid<=0; goto ACCUM; next beat is accepted the following cycle.
- Single-beat frame (in_last on first beat) is legal: out_beats=1, out_sum=in_data.
- Saturation:
  - Sum is computed in ACC_W+1 bits; if the result exceeds 2^ACC_W-1, clamp and set ovf.
  - Once saturated, acc stays at max for the rest of the frame.
- Counter saturation: cnt clamps at 2^CNT_W-1; no flag.
- Out-of-range input is still added (no clamp); only err is set.
- in_valid=0: no state change; in_data and in_last are ignored.
- in_valid held high while in_ready=0 (HOLD): beat is not consumed; upstream must hold it.
- Reset asserted mid-frame or in HOLD: immediate return to reset values; the partial frame is discarded.

Test Plan:
- Three-beat frame 21, 16, 12 (gpc606_5 vectors 2f/2b, 3c/16, 3a/12), last on 12, out_ready=1 -> out_valid one cycle after third accept; out_sum=49, out_beats=3, ovf=0, err=0.
- Single beat 0x1e, last=1 -> out_sum=30, out_beats=1; in_ready=0 until out_ready handshake.
- Backpressure: out_ready=0 for 5 cycles after frame total 49, in_valid held high with 7 -> in_ready=0 throughout and outputs stable; on out_ready=1, 7 is accepted the next cycle and starts a new frame.
- ACC_W=6: beats 30, 30, 10, last -> out_sum=63, out_ovf=1; the next frame 5, last -> out_sum=5, ovf=0.
- Beat value 31 then 2, last -> out_sum=33, out_err=1; the following frame err=0.
- Reset pulsed mid-frame after beats 20, 20 -> all outputs 0; next frame 4, last -> out_sum=4, out_beats=1.

Source files
------------

// File: rtl/gpc_sum_accum.sv
`default_nettype none
// ============================================================================
// Module      : gpc_sum_accum
// Description : Streaming frame accumulator for gpc606_5 results. Sums the
//               beats of a frame with saturation, counts beats, flags
//               overflow and out-of-range inputs, and presents one registered
//               frame total behind a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module gpc_sum_accum #(
    parameter int IN_W   = 5,
    parameter int MAX_IN = 30,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_ovf,
    output logic             out_err
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] c_acc_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [IN_W-1:0]  c_max_in  = IN_W'(MAX_IN);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_beats_q, out_beats_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_err_q, out_err_d;

    logic [ACC_W:0]     w_sum_ext;
    logic [ACC_W-1:0]   w_acc_sat;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_ovf_next;
    logic               w_err_next;
    logic               w_accept;

    // Running-sum arithmetic for the beat on the input, one bit wider so the
    // carry doubles as the overflow indicator; a saturated accumulator stays
    // at its maximum because any further addend re-raises the carry.
    always_comb begin
        w_sum_ext  = {1'b0, acc_q} + (ACC_W+1)'(in_data);
        w_acc_sat  = w_sum_ext[ACC_W] ? c_acc_max : w_sum_ext[ACC_W-1:0];
        w_cnt_inc  = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + 1'b1;
        w_ovf_next = ovf_q | w_sum_ext[ACC_W];
        w_err_next = err_q | (in_data > c_max_in);
        w_accept   = in_valid && (state_q == ST_ACCUM);
    end

    // Next-state and datapath control for the ACCUM/HOLD handshake machine.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_beats_d = out_beats_q;
        out_ovf_d   = out_ovf_q;
        out_err_d   = out_err_q;
        in_ready    = 1'b0;

        case (state_q)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    if (in_last) begin
                        out_sum_d   = w_acc_sat;
                        out_beats_d = w_cnt_inc;
                        out_ovf_d   = w_ovf_next;
                        out_err_d   = w_err_next;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        err_d       = 1'b0;
                        state_d     = ST_HOLD;
                    end else begin
                        acc_d = w_acc_sat;
                        cnt_d = w_cnt_inc;
                        ovf_d = w_ovf_next;
                        err_d = w_err_next;
                    end
                end
            end
            ST_HOLD: begin
                // Input is stalled until the total has been taken, which
                // keeps out_ready from reaching in_ready combinationally.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_beats_q <= out_beats_d;
            out_ovf_q   <= out_ovf_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_beats = out_beats_q;
    assign out_ovf   = out_ovf_q;
    assign out_err   = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_gpc_sum_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpc_sum_accum
// Description : Self-checking bench for gpc_sum_accum. Two instances (16-bit
//               and 6-bit accumulator) share one stimulus stream; totals are
//               compared against a table of constants and an arithmetic
//               frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpc_sum_accum;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [4:0]  in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_ovf_a, out_err_a;
    logic [15:0] out_sum_a;
    logic [7:0]  out_beats_a;
    logic        in_ready_b, out_valid_b, out_ovf_b, out_err_b;
    logic [5:0]  out_sum_b;
    logic [7:0]  out_beats_b;

    int n_checks = 0;
    int n_fail   = 0;

    gpc_sum_accum #(.IN_W(5), .MAX_IN(30), .ACC_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(out_sum_a),
        .out_beats(out_beats_a), .out_ovf(out_ovf_a), .out_err(out_err_a)
    );

    gpc_sum_accum #(.IN_W(5), .MAX_IN(30), .ACC_W(6), .CNT_W(8)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b),
        .out_beats(out_beats_b), .out_ovf(out_ovf_b), .out_err(out_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]      n;
        logic [3:0][4:0] d;     // d[0] is the first beat
        logic [15:0]     sum16;
        logic [5:0]      sum6;
        logic [7:0]      beats;
        logic            ovf16;
        logic            ovf6;
        logic            err;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame reference: total of all beats clamped to the accumulator range.
    function automatic void model(input int q[$], input int accw, output longint sum,
                                  output longint beats, output longint ovf, output longint err);
        longint total = 0;
        longint maxv  = (longint'(1) << accw) - 1;
        err = 0;
        foreach (q[i]) begin
            total += q[i];
            if (q[i] > 30) err = 1;
        end
        sum   = (total > maxv) ? maxv : total;
        ovf   = (total > maxv) ? 1 : 0;
        beats = (q.size() > 255) ? 255 : q.size();
    endfunction

    // Offer one beat and wait (bounded) until it is taken.
    task automatic send(input int d, input bit last);
        bit taken = 0;
        in_valid = 1'b1;
        in_data  = 5'(d);
        in_last  = last;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready_a) begin
                taken = 1;
                break;
            end
        end
        if (!taken) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called one step after the last beat's accepting edge.
    task automatic check_total(input string tag, input longint s16, input longint s6,
                               input longint beats, input longint ovf16, input longint ovf6,
                               input longint err);
        check({tag, ".valid16"}, out_valid_a, 1);
        check({tag, ".valid6"},  out_valid_b, 1);
        check({tag, ".sum16"},   out_sum_a, s16);
        check({tag, ".sum6"},    out_sum_b, s6);
        check({tag, ".beats"},   out_beats_a, beats);
        check({tag, ".beats6"},  out_beats_b, beats);
        check({tag, ".ovf16"},   out_ovf_a, ovf16);
        check({tag, ".ovf6"},    out_ovf_b, ovf6);
        check({tag, ".err"},     out_err_a, err);
        check({tag, ".err6"},    out_err_b, err);
        check({tag, ".hold_rdy"}, in_ready_a, 0);
    endtask

    task automatic ack(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".ack_valid"}, out_valid_a, 0);
        check({tag, ".ack_rdy"},   in_ready_a, 1);
    endtask

    task automatic run_frame(input string tag, input int q[$]);
        longint s16, s6, b, o16, o6, e;
        foreach (q[i]) send(q[i], i == q.size() - 1);
        model(q, 16, s16, b, o16, e);
        model(q, 6,  s6,  b, o6,  e);
        check_total(tag, s16, s6, b, o16, o6, e);
        ack(tag);
    endtask

    vec_t tbl[7];

    initial begin
        int q[$];
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;

        tbl[0] = '{3'd3, {5'd0, 5'd12, 5'd16, 5'd21}, 16'd49, 6'd49, 8'd3, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{3'd1, {5'd0, 5'd0, 5'd0, 5'd30},   16'd30, 6'd30, 8'd1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{3'd2, {5'd0, 5'd0, 5'd2, 5'd31},   16'd33, 6'd33, 8'd2, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{3'd1, {5'd0, 5'd0, 5'd0, 5'd4},    16'd4,  6'd4,  8'd1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{3'd3, {5'd0, 5'd10, 5'd30, 5'd30}, 16'd70, 6'd63, 8'd3, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{3'd1, {5'd0, 5'd0, 5'd0, 5'd5},    16'd5,  6'd5,  8'd1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{3'd4, {5'd0, 5'd0, 5'd0, 5'd0},    16'd0,  6'd0,  8'd4, 1'b0, 1'b0, 1'b0};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst.valid", out_valid_a, 0);
        check("rst.sum",   out_sum_a, 0);
        check("rst.beats", out_beats_a, 0);
        check("rst.ovf",   out_ovf_a, 0);
        check("rst.err",   out_err_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst.in_ready", in_ready_a, 1);

        // Table of frames with constant expectations
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < int'(tbl[k].n); i++)
                send(int'(tbl[k].d[i]), i == int'(tbl[k].n) - 1);
            check_total($sformatf("tbl%0d", k), tbl[k].sum16, tbl[k].sum6,
                        tbl[k].beats, tbl[k].ovf16, tbl[k].ovf6, tbl[k].err);
            ack($sformatf("tbl%0d", k));
        end

        // Backpressure: total 49 held while a new beat waits upstream
        send(21, 0);
        send(16, 0);
        send(12, 1);
        in_valid = 1'b1;
        in_data  = 5'd7;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp.in_ready", in_ready_a, 0);
            check("bp.valid",    out_valid_a, 1);
            check("bp.sum",      out_sum_a, 49);
            check("bp.beats",    out_beats_a, 3);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp.ack_valid", out_valid_a, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_total("bp.next", 7, 7, 1, 0, 0, 0);
        ack("bp.next");

        // Reset mid-frame discards the partial sum and clears held outputs
        send(20, 0);
        send(20, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid.valid", out_valid_a, 0);
        check("mid.sum",   out_sum_a, 0);
        check("mid.beats", out_beats_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q = '{4};
        run_frame("mid.next", q);

        // Randomized frames against the arithmetic model
        for (int f = 0; f < 25; f++) begin
            int len = $urandom_range(1, 8);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back($urandom_range(0, 31));
            run_frame($sformatf("rnd%0d", f), q);
        end

        // Long frame drives the beat counter into saturation
        q.delete();
        for (int i = 0; i < 300; i++) q.push_back($urandom_range(0, 31));
        run_frame("long", q);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
